// File: rtl/burst_dac_gen.sv
// rtl/burst_dac_gen.sv - fixed-length burst sample source with derived sample clock
module burst_dac_gen #(
  parameter int DIV       = 8,
  parameter int BURST_LEN = 255
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        gen_start,
  input  logic [11:0] amp,
  input  logic [1:0]  wave_sel,
  input  logic [7:0]  freq,
  output logic        clk_samp,
  output logic        samp_valid,
  output logic [11:0] DA_data,
  output logic        busy,
  output logic        gen_done
);

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [15:0]   LEN      = 16'(BURST_LEN);

  localparam logic [1:0] WAVE_DC  = 2'b00;
  localparam logic [1:0] WAVE_SQ  = 2'b01;
  localparam logic [1:0] WAVE_TRI = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [11:0]     amp_l;
  logic [1:0]      wave_l;
  logic [7:0]      freq_l;
  logic [7:0]      phase;
  logic [DW-1:0]   div_cnt;
  logic [15:0]     samp_cnt;

  logic            wrap;
  logic            burst_end;
  logic [DW-1:0]   div_nxt;
  logic [15:0]     cnt_nxt;
  logic [7:0]      tri_t;
  logic [7:0]      mult;
  logic [11:0]     scaled;
  logic [11:0]     wave_val;

  // Divider/sample-count look-ahead so clk_samp can be registered in step with div_cnt
  always_comb begin
    wrap      = (div_cnt == DIV_LAST);
    burst_end = (samp_cnt == LEN);
    div_nxt   = wrap ? '0 : div_cnt + 1'b1;
    cnt_nxt   = samp_cnt + 16'(wrap);
  end

  // Waveform value for the current phase; products are truncated, never rounded
  always_comb begin
    // Triangle folds at mid-period: (255-phase) is ~phase when phase[7] is set
    tri_t    = phase[7] ? {~phase[6:0], 1'b0} : {phase[6:0], 1'b0};
    mult     = (wave_l == WAVE_TRI) ? tri_t : phase;
    scaled   = 12'(({8'b0, amp_l} * {12'b0, mult}) >> 8);
    case (wave_l)
      WAVE_DC: wave_val = amp_l;
      WAVE_SQ: wave_val = phase[7] ? 12'd0 : amp_l;
      default: wave_val = scaled;
    endcase
  end

  // Burst FSM with registered outputs
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= IDLE;
      amp_l      <= '0;
      wave_l     <= '0;
      freq_l     <= '0;
      phase      <= '0;
      div_cnt    <= '0;
      samp_cnt   <= '0;
      clk_samp   <= 1'b0;
      samp_valid <= 1'b0;
      DA_data    <= '0;
      busy       <= 1'b0;
      gen_done   <= 1'b0;
    end else begin
      samp_valid <= 1'b0;
      gen_done   <= 1'b0;
      case (state)
        IDLE: begin
          clk_samp <= 1'b0;
          if (gen_start) begin
            amp_l    <= amp;
            wave_l   <= wave_sel;
            freq_l   <= freq;
            busy     <= 1'b1;
            div_cnt  <= '0;
            phase    <= '0;
            samp_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (burst_end) begin
            // One cycle after the final sample's strobe
            state    <= IDLE;
            busy     <= 1'b0;
            gen_done <= 1'b1;
            DA_data  <= '0;
            clk_samp <= 1'b0;
            div_cnt  <= '0;
          end else begin
            div_cnt  <= div_nxt;
            samp_cnt <= cnt_nxt;
            // High for the first half of each sample period once a sample exists
            clk_samp <= (div_nxt < DIV_HALF) && (cnt_nxt != 16'd0);
            if (wrap) begin
              samp_valid <= 1'b1;
              DA_data    <= wave_val;
              phase      <= phase + freq_l;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_dac_gen.sv
// tb/tb_burst_dac_gen.sv - self-checking bench for burst_dac_gen
module tb_burst_dac_gen;

  localparam int DIV = 8;
  localparam int BL  = 255;
  localparam int END_N = DIV * BL;

  logic        clk_sys;
  logic        rst;
  logic        gen_start;
  logic [11:0] amp;
  logic [1:0]  wave_sel;
  logic [7:0]  freq;
  logic        clk_samp;
  logic        samp_valid;
  logic [11:0] DA_data;
  logic        busy;
  logic        gen_done;

  int n_checks;
  int n_fail;

  burst_dac_gen #(.DIV(DIV), .BURST_LEN(BL)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .gen_start  (gen_start),
    .amp        (amp),
    .wave_sel   (wave_sel),
    .freq       (freq),
    .clk_samp   (clk_samp),
    .samp_valid (samp_valid),
    .DA_data    (DA_data),
    .busy       (busy),
    .gen_done   (gen_done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Reference waveform value from the plain arithmetic definition
  function automatic int model_sample(int wave, int a, int ph);
    int t;
    case (wave)
      0: return a;
      1: return (ph < 128) ? a : 0;
      2: begin
        t = (ph < 128) ? 2 * ph : 2 * (255 - ph);
        return (a * t) / 256;
      end
      default: return (a * ph) / 256;
    endcase
  endfunction

  // Issue a burst from the current time (#1 after an edge) and check every cycle up to gen_done.
  // Returns the energy sum/count of values captured at clk_samp rising edges.
  task automatic run_burst(input string tag, input int a, input int w, input int f,
                           input int glitch_n, output longint esum, output int ecnt);
    int ev, eb, ed, ec, eda, k, ph;
    logic prev_clk;
    esum = 0;
    ecnt = 0;
    prev_clk = 1'b0;
    amp = 12'(a);
    wave_sel = 2'(w);
    freq = 8'(f);
    gen_start = 1'b1;
    @(posedge clk_sys);
    #1;
    gen_start = 1'b0;
    for (int n = 1; n <= END_N + 1; n++) begin
      if (n == glitch_n) begin
        gen_start = 1'b1;
        amp = 12'($urandom);
        wave_sel = 2'($urandom);
        freq = 8'($urandom);
      end else begin
        gen_start = 1'b0;
      end
      @(posedge clk_sys);
      #1;
      ev  = (n >= DIV && n <= END_N && n % DIV == 0) ? 1 : 0;
      eb  = (n <= END_N) ? 1 : 0;
      ed  = (n == END_N + 1) ? 1 : 0;
      ec  = (n >= DIV && n <= END_N && (n % DIV) < DIV / 2) ? 1 : 0;
      if (n < DIV || n > END_N) begin
        eda = 0;
      end else begin
        k   = n / DIV;
        ph  = ((k - 1) * f) % 256;
        eda = model_sample(w, a, ph);
      end
      n_checks += 5;
      if (samp_valid !== 1'(ev)) begin
        n_fail++;
        $display("FAIL %s samp_valid n=%0d got %0b exp %0d", tag, n, samp_valid, ev);
      end
      if (busy !== 1'(eb)) begin
        n_fail++;
        $display("FAIL %s busy n=%0d got %0b exp %0d", tag, n, busy, eb);
      end
      if (gen_done !== 1'(ed)) begin
        n_fail++;
        $display("FAIL %s gen_done n=%0d got %0b exp %0d", tag, n, gen_done, ed);
      end
      if (clk_samp !== 1'(ec)) begin
        n_fail++;
        $display("FAIL %s clk_samp n=%0d got %0b exp %0d", tag, n, clk_samp, ec);
      end
      if (DA_data !== 12'(eda)) begin
        n_fail++;
        $display("FAIL %s DA_data n=%0d got %0d exp %0d", tag, n, DA_data, eda);
      end
      if (clk_samp === 1'b1 && prev_clk === 1'b0) begin
        esum += longint'(DA_data) * longint'(DA_data);
        ecnt++;
      end
      prev_clk = clk_samp;
    end
    gen_start = 1'b0;
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    gen_start = 1'b1;
    amp = 12'd500;
    wave_sel = 2'b00;
    freq = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys);
      #1;
      n_checks++;
      if ({clk_samp, samp_valid, DA_data, busy, gen_done} !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle=%0d got %0h exp 0", i,
                 {clk_samp, samp_valid, DA_data, busy, gen_done});
      end
    end
    gen_start = 1'b0;
    rst = 1'b0;
    idle_cycles(3);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored busy got %0b exp 0", busy);
    end
  endtask

  task automatic test_dc;
    longint es; int ec;
    idle_cycles(4);
    run_burst("dc", 100, 0, 37, 0, es, ec);
    n_checks++;
    if (ec != BL) begin
      n_fail++;
      $display("FAIL dc_clk_edges got %0d exp %0d", ec, BL);
    end
  endtask

  task automatic test_sawtooth;
    longint es; int ec;
    idle_cycles(2);
    run_burst("saw", 4095, 3, 64, 0, es, ec);
    n_checks++;
    if (ec != BL) begin
      n_fail++;
      $display("FAIL saw_clk_edges got %0d exp %0d", ec, BL);
    end
  endtask

  task automatic test_triangle;
    longint es; int ec;
    idle_cycles(2);
    run_burst("tri", 256, 2, 32, 0, es, ec);
  endtask

  task automatic test_square;
    longint es; int ec;
    idle_cycles(2);
    run_burst("square", 2000, 1, 128, 0, es, ec);
    idle_cycles(2);
    run_burst("amp0", 0, 1, 128, 0, es, ec);
    n_checks++;
    if (es != 0) begin
      n_fail++;
      $display("FAIL amp0_energy got %0d exp 0", es);
    end
  endtask

  task automatic test_ignore_start;
    longint es; int ec;
    idle_cycles(2);
    run_burst("ignore_start", 1234, 3, 17, 100, es, ec);
  endtask

  task automatic test_reset_mid;
    longint es; int ec;
    idle_cycles(2);
    amp = 12'd3000;
    wave_sel = 2'b11;
    freq = 8'd5;
    gen_start = 1'b1;
    @(posedge clk_sys);
    #1;
    gen_start = 1'b0;
    repeat (DIV * 10) @(posedge clk_sys);
    #1;
    n_checks++;
    if (samp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_sample10 samp_valid got %0b exp 1", samp_valid);
    end
    rst = 1'b1;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({clk_samp, samp_valid, DA_data, busy, gen_done} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got %0h exp 0",
               {clk_samp, samp_valid, DA_data, busy, gen_done});
    end
    for (int i = 0; i < DIV * BL; i++) begin
      @(posedge clk_sys);
      #1;
      n_checks++;
      if (gen_done !== 1'b0 || busy !== 1'b0 || samp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet cycle=%0d done=%0b busy=%0b valid=%0b exp 0",
                 i, gen_done, busy, samp_valid);
      end
    end
    run_burst("fresh_after_rst", 4095, 3, 64, 0, es, ec);
  endtask

  task automatic test_back_to_back;
    longint es; int ec;
    idle_cycles(2);
    run_burst("b2b_first", 777, 2, 9, 0, es, ec);
    // gen_done is high now; start again immediately
    run_burst("b2b_second", 4000, 1, 200, 0, es, ec);
  endtask

  task automatic test_freq_zero;
    longint es; int ec;
    idle_cycles(2);
    run_burst("f0_tri", 3333, 2, 0, 0, es, ec);
    n_checks++;
    if (es != 0) begin
      n_fail++;
      $display("FAIL f0_tri_energy got %0d exp 0", es);
    end
    idle_cycles(2);
    run_burst("f0_square", 3333, 1, 0, 0, es, ec);
  endtask

  task automatic test_random;
    longint es; int ec;
    for (int r = 0; r < 3; r++) begin
      idle_cycles(1 + ($urandom % 5));
      run_burst("random", int'($urandom % 4096), int'($urandom % 4), int'($urandom % 256),
                0, es, ec);
    end
  endtask

  task automatic test_loopback;
    longint es; int ec;
    idle_cycles(2);
    run_burst("loopback", 256, 0, 0, 0, es, ec);
    n_checks++;
    if (ec == 0 || es / ec != 65536) begin
      n_fail++;
      $display("FAIL loopback_mean_energy got %0d/%0d exp mean 65536", es, ec);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    gen_start = 1'b0;
    amp = '0;
    wave_sel = '0;
    freq = '0;
    test_reset;
    test_dc;
    test_sawtooth;
    test_triangle;
    test_square;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_freq_zero;
    test_random;
    test_loopback;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_dac_gen.md
Name: burst_dac_gen

Overview:
- Burst sample source: the transmit-side counterpart to the AD sample-energy measure path.
- On a start request it emits a fixed-length burst of unsigned 12-bit samples (DC, square, triangle or sawtooth, programmable amplitude and phase step).
- Each sample comes with a one-cycle valid strobe and a derived sample clock.
- Used to drive the DAC, or looped back into the measurement chain for self-test of sample energy.

Parameters:
DIV, 8, clk_sys cycles per sample; legal values are even and >= 2.
BURST_LEN, 255, samples per burst; legal range 1..65535.

Ports:
clk_sys  in  1  system clock; sole clock domain.
rst  in  1  synchronous, active-high reset.
gen_start  in  1  single-cycle burst request; honoured only in IDLE.
amp  in  12  unsigned peak amplitude; latched when gen_start is accepted.
wave_sel  in  2  waveform select: 00 DC, 01 square, 10 triangle, 11 sawtooth; latched on accept.
freq  in  8  phase increment per sample, in 1/256 of a waveform period; latched on accept.
clk_samp  out  1  derived sample clock; rising edge coincides with a new DA_data value.
samp_valid  out  1  one-cycle strobe marking a new DA_data value.
DA_data  out  12  current sample, unsigned.
busy  out  1  high while a burst is running.
gen_done  out  1  one-cycle pulse after the last sample of a burst.

Behaviour:
- All outputs are registered. Reset values: clk_samp=0, samp_valid=0, DA_data=0, busy=0, gen_done=0. Internal phase, div_cnt and sample count also clear to 0.
- States:
  - IDLE -> RUN on gen_start.
  - RUN -> IDLE after BURST_LEN samples.
  - gen_start while in RUN is ignored and has no side effects.
- Accept edge: amp, wave_sel and freq are latched; busy<=1; div_cnt<=0; phase<=0; sample count<=0.
- div_cnt counts 0..DIV-1 in RUN.
  - On the edge where div_cnt==DIV-1, div_cnt wraps to 0, samp_valid<=1 and DA_data<=f(phase).
  - On that same edge, phase<=phase+freq (mod 256) and sample count increments.
  - samp_valid is 0 on every other edge.
- First samp_valid occurs DIV cycles after the accept edge. Samples are then spaced exactly DIV cycles apart.
- Waveform f(phase), where P is the 12-bit latched amp:
  - DC: P.
  - Square: phase[7]==0 ? P : 0.
  - Sawtooth: (P*phase)>>8.
  - Triangle: t = phase<128 ? phase<<1 : (255-phase)<<1, giving an 8-bit value; output is (P*t)>>8.
  - Product is 20 bits and is truncated, never rounded. Result is always <= P, so no overflow.
- clk_samp:
  - 1 when div_cnt < DIV/2 and at least one sample of the current burst has been issued; otherwise 0.
  - Therefore no edge occurs before the first sample, and clk_samp is 0 in IDLE.
  - Rising edge coincides with samp_valid, so a consumer with a 2-FF edge detector sees stable data.
- Completion:
  - On the edge following the BURST_LEN-th sample's valid cycle: gen_done<=1 for one cycle, busy<=0, DA_data<=0, clk_samp<=0, state returns to IDLE.
  - gen_start on the same cycle gen_done is high is accepted, since the block is already in IDLE.
- Boundary cases:
  - amp=0: a full burst of zeros is still produced and gen_done fires.
  - freq=0: phase stays at 0, so DC=P, square=P, triangle=0, sawtooth=0.
  - BURST_LEN=1: one sample, then gen_done.
- rst asserted mid-burst: all outputs and state return to reset values on that edge; no gen_done is produced.
- gen_start asserted together with rst: rst wins.

Test Plan:
- DC, amp=100, DIV=8, BURST_LEN=255, start at edge 0 -> samp_valid at edges 8,16,…,2040, each with DA_data=100; gen_done at edge 2041; busy=0 and DA_data=0 at the same edge.
- Sawtooth, amp=4095, freq=64 -> DA_data sequence 0,1023,2047,3071 repeating for the whole burst; clk_samp high 4 cycles, low 4 cycles, rising edges aligned with samp_valid; no clk_samp edge before the first sample.
- Triangle, amp=256, freq=32 -> DA_data sequence 0,64,128,192,254,190,126,62 repeating.
- Square, amp=2000, freq=128 -> DA_data alternates 2000,0; amp=0 -> 255 zero samples, then gen_done.
- gen_start pulsed at edge 100 during a burst -> no change to timing, count or latched fields. rst at sample 10 -> all outputs 0 next edge and no gen_done. A fresh gen_start afterwards -> full 255-sample burst with phase starting at 0.
- Loopback: DA_data to the measurement AD input and clk_samp to its sample clock, DC amp=256, BURST_LEN>=256 -> measured mean energy = 256*256 = 65536, within truncation of the divide-by-256.
